// File: rtl/arb_pkg.sv
// Requester identifiers for the instruction/data memory arbiter.
package arb_pkg;
    typedef enum logic {
        ReqInst = 1'b0,
        ReqData = 1'b1
    } req_id_e;
endpackage

// File: rtl/core_pkg.sv
// Core-wide widths shared by the memory-facing blocks.
package core_pkg;
    localparam int unsigned Xlen     = 32;
    localparam int unsigned MaskBits = Xlen / 8;
endpackage

// File: rtl/arb_id_fifo.sv
// In-order 1-bit ID FIFO recording which requester owns each outstanding access.
module arb_id_fifo #(
    parameter int unsigned Depth = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic push_data_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth) + 1;

    logic [Depth-1:0] mem_q, mem_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store; data is favoured,
// a starvation counter guarantees fetch progress, an ID FIFO routes responses.
module mem_arbiter
    import core_pkg::*;
    import arb_pkg::*;
#(
    parameter int unsigned Depth       = 4,
    parameter int unsigned StarveLimit = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                inst_valid_i,
    output logic                inst_ready_o,
    input  logic [Xlen-1:0]     inst_addr_i,
    input  logic [Xlen-1:0]     inst_wdata_i,
    input  logic [MaskBits-1:0] inst_wmask_i,
    output logic [Xlen-1:0]     inst_rdata_o,
    output logic                inst_rvalid_o,
    input  logic                data_valid_i,
    output logic                data_ready_o,
    input  logic [Xlen-1:0]     data_addr_i,
    input  logic [Xlen-1:0]     data_wdata_i,
    input  logic [MaskBits-1:0] data_wmask_i,
    output logic [Xlen-1:0]     data_rdata_o,
    output logic                data_rvalid_o,
    output logic                mem_valid_o,
    input  logic                mem_ready_i,
    output logic [Xlen-1:0]     mem_addr_o,
    output logic [Xlen-1:0]     mem_wdata_o,
    output logic [MaskBits-1:0] mem_wmask_o,
    input  logic [Xlen-1:0]     mem_rdata_i,
    input  logic                mem_rvalid_i,
    output logic                err_o
);
    localparam int unsigned StarveW = $clog2(StarveLimit + 1);

    logic               lock_q, lock_d;
    req_id_e            owner_q, owner_d;
    logic [StarveW-1:0] starve_q, starve_d;
    logic               err_q, err_d;

    req_id_e grant;
    logic    grant_act;
    logic    grant_valid;
    logic    starving;
    logic    accept;
    logic    pop;
    logic    fifo_full;
    logic    fifo_empty;
    logic    fifo_head;

    assign starving = (starve_q == StarveW'(StarveLimit));

    // A stalled request keeps its grant so mem_* stay stable until accepted.
    always_comb begin
        grant     = ReqData;
        grant_act = 1'b0;
        if (lock_q) begin
            grant     = owner_q;
            grant_act = 1'b1;
        end else if (!fifo_full) begin
            if (data_valid_i && !starving) begin
                grant     = ReqData;
                grant_act = 1'b1;
            end else if (inst_valid_i) begin
                grant     = ReqInst;
                grant_act = 1'b1;
            end else if (data_valid_i) begin
                grant     = ReqData;
                grant_act = 1'b1;
            end
        end
    end

    always_comb begin
        grant_valid   = (grant == ReqData) ? data_valid_i : inst_valid_i;
        mem_valid_o   = grant_act & grant_valid & ~fifo_full;
        mem_addr_o    = (grant == ReqData) ? data_addr_i  : inst_addr_i;
        mem_wdata_o   = (grant == ReqData) ? data_wdata_i : inst_wdata_i;
        mem_wmask_o   = (grant == ReqData) ? data_wmask_i : inst_wmask_i;
        inst_ready_o  = grant_act & (grant == ReqInst) & mem_ready_i & ~fifo_full;
        data_ready_o  = grant_act & (grant == ReqData) & mem_ready_i & ~fifo_full;
        accept        = mem_valid_o & mem_ready_i;
        pop           = mem_rvalid_i & ~fifo_empty;
        inst_rvalid_o = pop & (fifo_head == 1'(ReqInst));
        data_rvalid_o = pop & (fifo_head == 1'(ReqData));
        inst_rdata_o  = mem_rdata_i;
        data_rdata_o  = mem_rdata_i;
        err_o         = err_q;
    end

    always_comb begin
        lock_d   = mem_valid_o & ~mem_ready_i;
        owner_d  = lock_d ? grant : owner_q;
        starve_d = starve_q;
        if (accept && grant == ReqData && inst_valid_i && !starving) begin
            starve_d = starve_q + StarveW'(1);
        end
        if ((accept && grant == ReqInst) || !inst_valid_i) begin
            starve_d = '0;
        end
        err_d = err_q | (mem_rvalid_i & fifo_empty);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q   <= 1'b0;
            owner_q  <= ReqInst;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            lock_q   <= lock_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    arb_id_fifo #(
        .Depth(Depth)
    ) u_id_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (accept),
        .push_data_i (grant),
        .pop_i       (pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (fifo_head)
    );
endmodule
